// File: rtl/frogger_pkg.sv
// frogger_pkg
// Shared definitions for the frog death monitor slice.
//   death_state_t    : life-cycle states of the frog (ALIVE/DYING/RESPAWN/DEAD)
//   TIME_LIMIT_DEF   : default ticks allowed per life
//   DEATH_TICKS_DEF  : default ticks the frog stays frozen after a death
//   TIME_W           : width of the per-life time counter (holds up to 63)
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_DYING   = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_DEAD    = 2'd3
    } death_state_t;

    localparam int TIME_LIMIT_DEF  = 30;
    localparam int DEATH_TICKS_DEF = 4;
    localparam int TIME_W          = 6;

endpackage

// File: rtl/frog_death_monitor_life_timer.sv
// life_timer
// Per-life down counter. Reloads to LIMIT on load_i (and on reset), counts
// down by one on each tick_i unless hold_i is set, and saturates at zero.
//   clk      : system clock
//   reset    : asynchronous, active-high; forces count to LIMIT
//   load_i   : reload count to LIMIT (wins over ticking)
//   tick_i   : game-step strobe
//   hold_i   : freeze the count
//   count_o  : registered remaining ticks
//   expire_o : this tick consumes the last remaining tick
module life_timer
    import frogger_pkg::*;
#(
    parameter int LIMIT = TIME_LIMIT_DEF,
    parameter int W     = TIME_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         tick_i,
    input  logic         hold_i,
    output logic [W-1:0] count_o,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic         step;

    assign step = tick_i && !hold_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= W'(LIMIT);
        end else if (load_i) begin
            count_q <= W'(LIMIT);
        end else if (step && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expire_o = step && (count_q == W'(1));
    assign count_o  = count_q;

endmodule

// File: rtl/frog_death_monitor.sv
// frog_death_monitor
// Watches the frog for collisions and per-life timeouts, emits a single loss
// pulse per death, freezes the frog for DEATH_TICKS ticks, then requests a
// respawn. Once the life counter reports game_over the monitor parks in DEAD
// until reset.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   tick       : one-clk game-step strobe
//   frog_col   : current frog column
//   hazard_row : hazard occupancy of the frog's row, bit i = column i
//   game_over  : lives exhausted (from the downstream life counter)
//   loss       : one-clk pulse per death
//   respawn    : one-clk pulse, frog returns to start square
//   frozen     : frog input must be ignored
//   time_left  : remaining ticks of the current life
module frog_death_monitor
    import frogger_pkg::*;
#(
    parameter int TIME_LIMIT  = TIME_LIMIT_DEF,
    parameter int DEATH_TICKS = DEATH_TICKS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  frog_col,
    input  logic [15:0] hazard_row,
    input  logic        game_over,
    output logic        loss,
    output logic        respawn,
    output logic        frozen,
    output logic [5:0]  time_left
);

    // Keep the limits inside what the 6-bit counter and death counter can hold.
    localparam int TL = (TIME_LIMIT > 63) ? 63 : ((TIME_LIMIT < 1) ? 1 : TIME_LIMIT);
    localparam int DT = (DEATH_TICKS < 1) ? 1 : DEATH_TICKS;
    localparam int DW = $clog2(DT + 1);

    death_state_t      state_q;
    logic [DW-1:0]     death_q;
    logic              loss_q;
    logic              respawn_q;
    logic              frozen_q;

    logic              collision;
    logic              timeout;
    logic              timer_load;
    logic              timer_hold;
    logic              death_last;
    logic [TIME_W-1:0] timer_count;

    // Collision is checked every clk, independent of tick.
    assign collision  = hazard_row[frog_col];
    assign death_last = (death_q <= DW'(1));
    // The life timer only runs while alive; it is reloaded as we leave DYING
    // so time_left already shows the fresh budget during the RESPAWN clk.
    assign timer_hold = (state_q != ST_ALIVE);
    assign timer_load = (state_q == ST_DYING) && tick && death_last;

    life_timer #(
        .LIMIT (TL),
        .W     (TIME_W)
    ) u_life_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .tick_i   (tick),
        .hold_i   (timer_hold),
        .count_o  (timer_count),
        .expire_o (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ALIVE;
            death_q   <= '0;
            loss_q    <= 1'b0;
            respawn_q <= 1'b0;
            frozen_q  <= 1'b0;
        end else begin
            loss_q    <= 1'b0;
            respawn_q <= 1'b0;
            case (state_q)
                ST_ALIVE: begin
                    // game_over takes precedence: no loss pulse when lives are gone.
                    if (game_over) begin
                        state_q  <= ST_DEAD;
                        frozen_q <= 1'b1;
                    end else if (collision || timeout) begin
                        state_q  <= ST_DYING;
                        death_q  <= DW'(DT);
                        loss_q   <= 1'b1;
                        frozen_q <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (tick) begin
                        if (death_last) begin
                            state_q   <= ST_RESPAWN;
                            death_q   <= '0;
                            respawn_q <= 1'b1;
                        end else begin
                            death_q <= death_q - DW'(1);
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (game_over) begin
                        state_q <= ST_DEAD;
                    end else begin
                        state_q  <= ST_ALIVE;
                        frozen_q <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    // Absorbing until reset.
                end
            endcase
        end
    end

    assign loss      = loss_q;
    assign respawn   = respawn_q;
    assign frozen    = frozen_q;
    assign time_left = timer_count;

endmodule

// File: tb/tb_frog_death_monitor.sv
module tb_frog_death_monitor;

    localparam int TL = 30;
    localparam int DT = 4;

    // Model phases of a frog's life (behavioural, not the RTL encoding).
    localparam int PH_LIVE   = 0;
    localparam int PH_FROZEN = 1;
    localparam int PH_BACK   = 2;
    localparam int PH_GONE   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  frog_col = 4'd0;
    logic [15:0] hazard_row = 16'h0;
    logic        game_over = 1'b0;
    logic        loss;
    logic        respawn;
    logic        frozen;
    logic [5:0]  time_left;

    logic [8:0]  dut_vec;

    frog_death_monitor #(
        .TIME_LIMIT  (TL),
        .DEATH_TICKS (DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .frog_col   (frog_col),
        .hazard_row (hazard_row),
        .game_over  (game_over),
        .loss       (loss),
        .respawn    (respawn),
        .frozen     (frozen),
        .time_left  (time_left)
    );

    always #5 clk = ~clk;

    assign dut_vec = {loss, respawn, frozen, time_left};

    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_phase;
    int   m_time;
    int   m_dleft;
    logic m_loss;
    logic m_resp;

    bit   chain_en = 1'b0;
    int   lives    = 0;

    function automatic logic [8:0] exp_vec();
        return {m_loss, m_resp, (m_phase != PH_LIVE), 6'(m_time)};
    endfunction

    task automatic model_reset();
        m_phase = PH_LIVE;
        m_time  = TL;
        m_dleft = 0;
        m_loss  = 1'b0;
        m_resp  = 1'b0;
    endtask

    // One clk of the frog's life, from the inputs present before the edge.
    task automatic model_step();
        bit to;
        m_loss = 1'b0;
        m_resp = 1'b0;
        case (m_phase)
            PH_LIVE: begin
                to = 1'b0;
                if (tick && m_time > 0) begin
                    to = (m_time == 1);
                    m_time = m_time - 1;
                end
                if (game_over) begin
                    m_phase = PH_GONE;
                end else if (hazard_row[frog_col] || to) begin
                    m_phase = PH_FROZEN;
                    m_loss  = 1'b1;
                    m_dleft = DT;
                end
            end
            PH_FROZEN: begin
                if (tick) begin
                    m_dleft = m_dleft - 1;
                    if (m_dleft == 0) begin
                        m_phase = PH_BACK;
                        m_resp  = 1'b1;
                        m_time  = TL;
                    end
                end
            end
            PH_BACK: m_phase = game_over ? PH_GONE : PH_LIVE;
            default: ;
        endcase
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
        // Behavioural life counter driven by the expected loss pulses.
        if (chain_en && m_loss) begin
            lives = lives - 1;
            game_over = (lives == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        tick       = 1'b0;
        hazard_row = 16'h0;
        game_over  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== {1'b0, 1'b0, 1'b0, 6'd30}) $display("FAIL reset_values: got %b required %b", dut_vec, {1'b0, 1'b0, 1'b0, 6'd30});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %b required %b", dut_vec, exp_vec());
        else n_pass++;
        $display("test_reset: loss=%0b respawn=%0b frozen=%0b time_left=%0d", loss, respawn, frozen, time_left);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= TL; i++) begin
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL timeout_tick %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
            if (i != TL) clk_step();
        end
        n_checks++;
        if ({loss, time_left, frozen} !== {1'b1, 6'd0, 1'b1}) $display("FAIL timeout_loss: got loss=%0b time_left=%0d frozen=%0b required 1/0/1", loss, time_left, frozen);
        else n_pass++;
        $display("test_timeout: loss=%0b time_left=%0d frozen=%0b", loss, time_left, frozen);
        for (int i = 0; i < DT + 2; i++) begin
            tick = 1'b1;
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL timeout_recover %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
        end
        tick = 1'b0;
    endtask

    task automatic test_collision();
        int n_loss;
        do_reset();
        n_loss = 0;
        frog_col   = 4'd5;
        hazard_row = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_loss += int'(loss);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL collision_hold %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
        end
        hazard_row = 16'h0;
        n_checks++;
        if (n_loss !== 1) $display("FAIL collision_single_loss: got %0d pulses required 1", n_loss);
        else n_pass++;
        for (int i = 0; i < DT; i++) begin
            tick = 1'b1;
            clk_step();
        end
        tick = 1'b0;
        n_checks++;
        if ({respawn, time_left} !== {1'b1, 6'd30}) $display("FAIL collision_respawn: got respawn=%0b time_left=%0d required 1/30", respawn, time_left);
        else n_pass++;
        clk_step();
        n_checks++;
        if ({respawn, frozen, time_left} !== {1'b0, 1'b0, 6'd30}) $display("FAIL collision_alive_again: got respawn=%0b frozen=%0b time_left=%0d required 0/0/30", respawn, frozen, time_left);
        else n_pass++;
        $display("test_collision: loss_pulses=%0d respawn=%0b frozen=%0b time_left=%0d", n_loss, respawn, frozen, time_left);
    endtask

    task automatic test_simultaneous();
        int n_loss;
        do_reset();
        frog_col = 4'd9;
        for (int i = 1; i < TL; i++) begin
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            clk_step();
        end
        n_loss = 0;
        tick = 1'b1;
        hazard_row = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            n_loss += int'(loss);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL simul_step %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
            hazard_row = (i < 2) ? 16'h0200 : 16'h0;
        end
        tick = 1'b0;
        hazard_row = 16'h0;
        n_checks++;
        if (n_loss !== 1) $display("FAIL simul_single_loss: got %0d pulses required 1", n_loss);
        else n_pass++;
        $display("test_simultaneous: loss_pulses=%0d time_left=%0d", n_loss, time_left);
    endtask

    task automatic test_game_over_dying();
        int n_loss;
        do_reset();
        frog_col   = 4'd0;
        hazard_row = 16'h0001;
        clk_step();
        hazard_row = 16'h0;
        game_over  = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick = 1'b1;
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL gameover_dying %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
        end
        tick = 1'b0;
        clk_step();
        n_loss = 0;
        for (int i = 0; i < 20; i++) begin
            hazard_row = 16'hFFFF;
            frog_col   = 4'($urandom_range(0, 15));
            tick       = 1'($urandom_range(0, 1));
            clk_step();
            n_loss += int'(loss);
            n_checks++;
            if (dut_vec !== exp_vec() || frozen !== 1'b1) $display("FAIL gameover_dead %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (n_loss !== 0) $display("FAIL gameover_no_loss: got %0d pulses required 0", n_loss);
        else n_pass++;
        do_reset();
        n_checks++;
        if (frozen !== 1'b0) $display("FAIL gameover_reset_frozen: got %0b required 0", frozen);
        else n_pass++;
        $display("test_game_over_dying: loss_in_dead=%0d frozen_after_reset=%0b", n_loss, frozen);
    endtask

    task automatic test_reset_mid_dying();
        do_reset();
        frog_col   = 4'd3;
        hazard_row = 16'h0008;
        clk_step();
        hazard_row = 16'h0;
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            clk_step();
            tick = 1'b0;
            clk_step();
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== {1'b0, 1'b0, 1'b0, 6'd30}) $display("FAIL middying_reset: got %b required %b", dut_vec, {1'b0, 1'b0, 1'b0, 6'd30});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick = 1'b1;
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec() || respawn !== 1'b0) $display("FAIL middying_after %0d: got %b required %b", i, dut_vec, exp_vec());
            else n_pass++;
        end
        tick = 1'b0;
        $display("test_reset_mid_dying: frozen=%0b respawn=%0b time_left=%0d", frozen, respawn, time_left);
    endtask

    task automatic test_chain();
        int n_loss;
        do_reset();
        chain_en = 1'b1;
        lives    = 3;
        n_loss   = 0;
        for (int d = 0; d < 3; d++) begin
            frog_col   = 4'($urandom_range(0, 15));
            hazard_row = 16'(1) << frog_col;
            clk_step();
            n_loss += int'(loss);
            hazard_row = 16'h0;
            tick = 1'b1;
            for (int i = 0; i < DT + 2; i++) begin
                clk_step();
                n_loss += int'(loss);
                n_checks++;
                if (dut_vec !== exp_vec()) $display("FAIL chain_death%0d_step%0d: got %b required %b", d, i, dut_vec, exp_vec());
                else n_pass++;
            end
            tick = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            hazard_row = 16'hFFFF;
            clk_step();
            n_loss += int'(loss);
        end
        hazard_row = 16'h0;
        n_checks++;
        if (n_loss !== 3 || frozen !== 1'b1) $display("FAIL chain_end: got loss_pulses=%0d frozen=%0b required 3/1", n_loss, frozen);
        else n_pass++;
        chain_en = 1'b0;
        $display("test_chain: loss_pulses=%0d lives=%0d frozen=%0b", n_loss, lives, frozen);
    endtask

    task automatic test_random();
        int dens;
        int bad;
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            dens = blk * 6;
            bad  = 0;
            for (int i = 0; i < 300; i++) begin
                tick       = 1'($urandom_range(0, 1));
                frog_col   = 4'($urandom_range(0, 15));
                hazard_row = ($urandom_range(0, 99) < dens) ? 16'($urandom) : 16'h0;
                game_over  = ($urandom_range(0, 249) == 0);
                clk_step();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    bad++;
                    if (bad < 5) $display("FAIL random_blk%0d_cyc%0d: got %b required %b", blk, i, dut_vec, exp_vec());
                end else begin
                    n_pass++;
                end
            end
            $display("test_random: block %0d density %0d mismatching_cycles=%0d", blk, dens, bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_timeout();
        test_collision();
        test_simultaneous();
        test_game_over_dying();
        test_reset_mid_dying();
        test_chain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frog_death_monitor.md
FROG_DEATH_MONITOR -- requirements
Module: frog_death_monitor

Interface
REQ-001 SHALL have parameter TIME_LIMIT, default 30, ticks allowed per life.
REQ-002 SHALL have parameter DEATH_TICKS, default 4, ticks the frog stays frozen after a death.
REQ-003 SHALL have clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have tick, input, 1, one-clk game-step strobe.
REQ-006 SHALL have frog_col, input, 4, current frog column.
REQ-007 SHALL have hazard_row, input, 16, hazard occupancy of the frog's current row; bit i = hazard in column i.
REQ-008 SHALL have game_over, input, 1, lives exhausted, driven by the downstream life counter.
REQ-009 SHALL have loss, output, 1, one-clk pulse per death; feeds the life counter's loss input.
REQ-010 SHALL have respawn, output, 1, one-clk pulse telling frog control to return to the start square.
REQ-011 SHALL have frozen, output, 1, high while frog input must be ignored.
REQ-012 SHALL have time_left, output, 6, remaining ticks of the current life.

Function
REQ-013 SHALL implement four states: ALIVE, DYING, RESPAWN, DEAD.
REQ-014 In ALIVE, collision SHALL be hazard_row[frog_col]==1, sampled every clk, not only on tick.
REQ-015 In ALIVE, each tick SHALL decrement time_left by 1; tick with time_left==1 SHALL be a timeout.
REQ-016 Collision or timeout in ALIVE SHALL assert loss for exactly the clk of the ALIVE->DYING transition (registered, 1-cycle latency).
REQ-017 Simultaneous collision and timeout SHALL produce a single loss pulse.
REQ-018 On entering DYING, the death counter SHALL load DEATH_TICKS and time_left SHALL hold its value (0 on timeout).
REQ-019 In DYING, frozen SHALL be 1, each tick SHALL decrement the death counter, and the tick at count 1 SHALL move to RESPAWN.
REQ-020 Collisions and timeouts SHALL be ignored outside ALIVE; no second loss pulse is ever produced per death.
REQ-021 RESPAWN SHALL last exactly one clk: respawn=1, frozen=1, time_left reloaded to TIME_LIMIT.
REQ-022 RESPAWN SHALL go to DEAD if game_over==1, otherwise to ALIVE.
REQ-023 game_over==1 in ALIVE SHALL go to DEAD without a loss pulse.
REQ-024 DEAD SHALL be absorbing until reset; frozen=1, loss=0, respawn=0, time_left held.
REQ-025 frozen SHALL be 0 only in ALIVE.
REQ-026 time_left SHALL never wrap below 0 nor exceed TIME_LIMIT; TIME_LIMIT SHALL be at most 63.

Reset
REQ-027 Reset SHALL force ALIVE, time_left=TIME_LIMIT, death counter=0, loss=0, respawn=0, frozen=0, including mid-DYING or in DEAD.
REQ-028 The first clk after reset deassertion SHALL be able to detect a collision.

Structure
REQ-029 A shared package frogger_pkg SHALL hold the state enum (death_state_t), TIME_LIMIT_DEF and DEATH_TICKS_DEF.
REQ-030 The per-life down counter SHALL be a sub-module life_timer (load, tick enable, hold, expire flag).
REQ-031 All outputs SHALL be registered; no combinational path from inputs to loss or respawn.

Verification
REQ-032 Reset, then 30 ticks with hazard_row=0 -> loss pulse on the clk after the 30th tick, time_left=0, frozen=1.
REQ-033 frog_col=5, hazard_row=16'h0020 held 3 clks in ALIVE -> exactly one loss pulse; 4 ticks later one respawn pulse, time_left=30, frozen=0 on the next clk.
REQ-034 Collision on the same clk as the timeout tick -> single loss pulse.
REQ-035 game_over=1 raised during DYING -> RESPAWN then DEAD; further hazards produce no loss; frozen stays 1 until reset.
REQ-036 Reset asserted mid-DYING after 2 ticks -> immediately ALIVE, time_left=30, frozen=0, no respawn pulse.
REQ-037 Chain three collisions into a life counter starting at 3 -> lives 3->2->1->0, game_over=1, monitor ends in DEAD.
